// File: rtl/pixel_frame_writer_pkg.sv
// Shared types and helpers for the pixel frame writer: FSM encoding,
// default geometry and RGB channel helpers.
package pixel_frame_writer_pkg;

  localparam int IMG_W_DEF   = 256;
  localparam int IMG_H_DEF   = 256;
  localparam int PIX_W_DEF   = 24;
  localparam int ADDR_W_DEF  = 16;
  localparam int GAP_MAX_DEF = 8;
  localparam int FRAME_PIX_DEF = IMG_W_DEF * IMG_H_DEF;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  function automatic logic [7:0] chan_r(input logic [23:0] p);
    return p[23:16];
  endfunction

  function automatic logic [7:0] chan_g(input logic [23:0] p);
    return p[15:8];
  endfunction

  function automatic logic [7:0] chan_b(input logic [23:0] p);
    return p[7:0];
  endfunction

  function automatic logic [9:0] rgb_sum(input logic [23:0] p);
    return {2'b00, chan_r(p)} + {2'b00, chan_g(p)} + {2'b00, chan_b(p)};
  endfunction

endpackage

// File: rtl/pixel_addr_gen.sv
// Row/column counters for the frame writer; produces the row-major linear
// address of the next pixel and flags the final pixel of the frame.
module pixel_addr_gen
  import pixel_frame_writer_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              last_pixel
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (clear) begin
      col <= '0;
      row <= '0;
    end else if (step) begin
      if (col == COL_LAST) begin
        col <= '0;
        // row only wraps together with the end of the frame
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  assign addr       = ADDR_W'(row) * ADDR_W'(IMG_W) + ADDR_W'(col);
  assign last_pixel = (col == COL_LAST) && (row == ROW_LAST);

endmodule

// File: rtl/pixel_frame_writer.sv
// Writes one IMG_W x IMG_H frame from the filter stream into the frame RAM.
// Define PIXEL_FRAME_WRITER_CHECKSUM_EN to build the R+G+B frame checksum.
//
// state   | meaning
// IDLE    | waiting for start; valid_in ignored
// ARMED   | start seen, waiting (unbounded) for the first pixel
// CAPTURE | writing pixels, idle gaps limited to GAP_MAX
// DONE    | one cycle, done pulse with the last write
module pixel_frame_writer
  import pixel_frame_writer_pkg::*;
#(
  parameter int IMG_W   = IMG_W_DEF,
  parameter int IMG_H   = IMG_H_DEF,
  parameter int PIX_W   = PIX_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int GAP_MAX = GAP_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [PIX_W-1:0]  pixel_in,
  input  logic              valid_in,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [PIX_W-1:0]  mem_wdata,
  output logic              mem_we,
  output logic              busy,
  output logic              done,
  output logic              frame_err,
  output logic [ADDR_W:0]   pix_count,
  output logic [31:0]       frame_sum
);

  localparam int GAP_W = $clog2(GAP_MAX + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_MAX - 1);

  state_t            state;
  logic [GAP_W-1:0]  gap;
  logic              clear;
  logic              step;
  logic [ADDR_W-1:0] next_addr;
  logic              last_pixel;

  assign clear = (state == S_IDLE) && start;
  assign step  = valid_in && ((state == S_ARMED) || (state == S_CAPTURE));

  pixel_addr_gen #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .step       (step),
    .addr       (next_addr),
    .last_pixel (last_pixel)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_err <= 1'b0;
      pix_count <= '0;
      gap       <= '0;
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_ARMED;
            busy      <= 1'b1;
            frame_err <= 1'b0;
            pix_count <= '0;
            gap       <= '0;
          end
        end
        S_ARMED, S_CAPTURE: begin
          if (valid_in) begin
            mem_we    <= 1'b1;
            mem_addr  <= next_addr;
            mem_wdata <= pixel_in;
            pix_count <= pix_count + 1'b1;
            gap       <= '0;
            if (last_pixel) begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= S_CAPTURE;
            end
          end else if (state == S_CAPTURE) begin
            // this idle cycle is the GAP_MAX-th in a row
            if (gap == GAP_LAST) begin
              frame_err <= 1'b1;
              busy      <= 1'b0;
              state     <= S_IDLE;
            end else begin
              gap <= gap + 1'b1;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef PIXEL_FRAME_WRITER_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_sum <= '0;
    end else if (clear) begin
      frame_sum <= '0;
    end else if (step) begin
      frame_sum <= frame_sum + 32'(rgb_sum(24'(pixel_in)));
    end
  end
`else
  assign frame_sum = '0;
`endif

endmodule

// File: tb/tb_pixel_frame_writer.sv
// Randomized self-checking bench for pixel_frame_writer on a reduced 16x8
// frame, compared each cycle against a behavioural frame-capture model.
module tb_pixel_frame_writer;

  localparam int W   = 16;
  localparam int H   = 8;
  localparam int N   = W * H;
  localparam int AW  = 8;
  localparam int GAP = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [23:0]   pixel_in;
  logic          valid_in;
  logic [AW-1:0] mem_addr;
  logic [23:0]   mem_wdata;
  logic          mem_we;
  logic          busy;
  logic          done;
  logic          frame_err;
  logic [AW:0]   pix_count;
  logic [31:0]   frame_sum;

  pixel_frame_writer #(
    .IMG_W   (W),
    .IMG_H   (H),
    .PIX_W   (24),
    .ADDR_W  (AW),
    .GAP_MAX (GAP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pixel_in  (pixel_in),
    .valid_in  (valid_in),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .busy      (busy),
    .done      (done),
    .frame_err (frame_err),
    .pix_count (pix_count),
    .frame_sum (frame_sum)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // model: phase 0 idle, 1 waiting for first pixel, 2 capturing, 3 done cycle
  int          ph;
  int          m_cnt;
  int          m_gap;
  bit          m_err;
  logic [31:0] m_sum;
  bit          e_we;
  bit          e_done;
  int          e_addr;
  logic [23:0] e_data;
  logic [31:0] sum_ff00ff;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    ph = 0; m_cnt = 0; m_gap = 0; m_err = 0; m_sum = 0;
  endtask

  // drive one cycle, advance the model, then compare just after the edge
  task automatic cyc(input bit s, input bit v, input logic [23:0] d);
    start = s; valid_in = v; pixel_in = d;
    e_we = 0; e_done = 0;
    if (ph == 3) begin
      ph = 0;
    end else if (ph == 0) begin
      if (s) begin
        ph = 1; m_cnt = 0; m_gap = 0; m_err = 0; m_sum = 0;
      end
    end else if (v) begin
      e_we = 1; e_addr = m_cnt; e_data = d;
      m_cnt++;
      m_gap = 0;
`ifdef PIXEL_FRAME_WRITER_CHECKSUM_EN
      m_sum = m_sum + 32'(d[23:16]) + 32'(d[15:8]) + 32'(d[7:0]);
`endif
      if (m_cnt == N) begin
        ph = 3; e_done = 1;
      end else begin
        ph = 2;
      end
    end else if (ph == 2) begin
      m_gap++;
      if (m_gap == GAP) begin
        m_err = 1; ph = 0;
      end
    end
    @(posedge clk);
    #1;
    check("we", 32'(mem_we), 32'(e_we));
    check("done", 32'(done), 32'(e_done));
    check("busy", 32'(busy), 32'(ph == 1 || ph == 2));
    check("err", 32'(frame_err), 32'(m_err));
    check("count", 32'(pix_count), m_cnt);
    check("sum", frame_sum, m_sum);
    if (e_we) begin
      check("addr", 32'(mem_addr), e_addr);
      check("data", 32'(mem_wdata), 32'(e_data));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; valid_in = 1'b0; pixel_in = '0;
    model_reset();
    @(posedge clk); #1;
    check("rst_we", 32'(mem_we), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_count", 32'(pix_count), 0);
    check("rst_sum", frame_sum, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // valid pulses in IDLE write nothing
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'($urandom % 2), 24'($urandom));

    // full frame, valid held, data = index, then extra pixels after done
    cyc(1'b1, 1'b0, 24'h0);
    for (int i = 0; i < N; i++) cyc(1'b0, 1'b1, 24'(i));
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 24'($urandom));
    check("hold_count", 32'(pix_count), N);

    // ARMED waits indefinitely without timing out
    cyc(1'b1, 1'b0, 24'h0);
    repeat (20) cyc(1'b0, 1'b0, 24'h0);
    check("armed_busy", 32'(busy), 1);

    // gaps up to GAP-1 with stray start pulses; frame must complete
    for (int i = 0; i < N; i++) begin
      cyc(1'($urandom % 4 == 0), 1'b1, 24'($urandom));
      if (i < N - 1) begin
        int g;
        g = (i % 10 == 0) ? GAP - 1 : int'($urandom_range(0, GAP - 1));
        repeat (g) cyc(1'($urandom % 8 == 0), 1'b0, 24'($urandom));
      end
    end
    check("gapped_err", 32'(frame_err), 0);
    // start coinciding with the DONE cycle is ignored
    cyc(1'b1, 1'b0, 24'h0);
    check("done_start", 32'(busy), 0);

    // exactly GAP idle cycles after pixel 50 aborts the frame
    cyc(1'b1, 1'b0, 24'h0);
    for (int i = 0; i < 51; i++) cyc(1'b0, 1'b1, 24'($urandom));
    repeat (GAP) cyc(1'b0, 1'b0, 24'h0);
    check("gap_err", 32'(frame_err), 1);
    check("gap_count", 32'(pix_count), 51);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 24'($urandom));

    // asynchronous reset between edges mid-frame
    cyc(1'b1, 1'b0, 24'h0);
    for (int i = 0; i < 40; i++) cyc(1'b0, 1'b1, 24'($urandom));
    #3 rst = 1'b1;
    #1;
    check("midrst_we", 32'(mem_we), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_count", 32'(pix_count), 0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;

    // new frame from addr 0 with constant pixel for the checksum
    cyc(1'b1, 1'b0, 24'h0);
    for (int i = 0; i < N; i++) cyc(1'b0, 1'b1, 24'hFF00FF);
`ifdef PIXEL_FRAME_WRITER_CHECKSUM_EN
    sum_ff00ff = 32'(N * 510);
`else
    sum_ff00ff = 32'd0;
`endif
    check("sum_ff00ff", frame_sum, sum_ff00ff);

    // random traffic: starts, valids and gaps that may or may not abort
    for (int i = 0; i < 600; i++)
      cyc(1'($urandom % 16 == 0), 1'($urandom % 3 != 0), 24'($urandom));
    for (int i = 0; i < 300; i++)
      cyc(1'($urandom % 8 == 0), 1'($urandom % 6 == 0), 24'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
